output_argmax: RTL and testbench
================================

OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 The module SHALL have parameter NUM_CLASSES, default 10, giving the number of scores per classification.
REQ-002 The module SHALL have parameter DATA_W, default 16, giving the score width in bits (two's complement).
REQ-003 The module SHALL have parameter IDX_W, default 4, giving the class index width; NUM_CLASSES SHALL NOT exceed 2^IDX_W.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit: arms a new classification.
REQ-007 The module SHALL have port in_valid, input, 1 bit: the upstream network's ready strobe, which qualifies in_data.
REQ-008 The module SHALL have port in_data, input, DATA_W bits: the signed score from the upstream network's out port.
REQ-009 The module SHALL have port busy, output, 1 bit: high while scores are being collected.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-011 The module SHALL have port class_idx, output, IDX_W bits: the index of the winning score.
REQ-012 The module SHALL have port max_score, output, DATA_W bits: the winning score value.

Function
REQ-013 The module SHALL implement a state machine with states IDLE, COLLECT and DONE.
REQ-014 IDLE SHALL go to COLLECT on the clock edge where start=1; in the same edge, the sample counter and class_idx SHALL clear to 0, max_score SHALL load the most negative DATA_W value, and busy SHALL go to 1.
REQ-015 In IDLE, in_valid SHALL be ignored; no sample is counted.
REQ-016 In COLLECT, each cycle with in_valid=1 SHALL accept one sample and increment the counter, which runs 0..NUM_CLASSES-1 and is the sample's class index.
REQ-017 An accepted sample SHALL replace max_score and class_idx only if it is strictly greater under a signed compare, so on ties the lowest index wins.
REQ-018 The first accepted sample SHALL always be taken as the running maximum, including when it equals the most negative value (index 0 wins).
REQ-019 In COLLECT, start SHALL be ignored; a running classification is not restarted.
REQ-020 On the edge that accepts sample NUM_CLASSES-1, the state SHALL go to DONE and busy SHALL go to 0.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, which is the cycle after the last sample is accepted; the next state SHALL be IDLE.
REQ-022 In DONE, in_valid SHALL be ignored, and start SHALL be ignored.
REQ-023 class_idx and max_score SHALL hold their final values from DONE until the next start is accepted in IDLE.
REQ-024 Gaps of any length between in_valid pulses SHALL NOT affect the result.
REQ-025 Back-to-back in_valid on consecutive cycles SHALL each be accepted.
REQ-026 No sample beyond NUM_CLASSES SHALL be accepted per classification, and the counter SHALL NOT wrap inside COLLECT.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 When rst=1 at a rising edge, the state SHALL become IDLE, and busy=0, done=0, class_idx=0, max_score=0 and counter=0.
REQ-029 rst SHALL take priority over start and in_valid in the same cycle.
REQ-030 rst asserted mid-COLLECT SHALL abort the classification with no done pulse.

Verification
REQ-031 Bench: reset, start, then scores 3,-5,7,2,7,0,1,-1,6,4 at 1-cycle spacing -> done one cycle after the 10th sample, class_idx=2, max_score=7 (tie resolved to the lower index).
REQ-032 Bench: all ten scores = -32768 with random gaps of 0-5 cycles -> class_idx=0, max_score=-32768, exactly one done pulse.
REQ-033 Bench: in_valid pulses while IDLE, then start, then ten scores with the maximum 100 at index 9 -> the idle pulses are ignored, class_idx=9, max_score=100.
REQ-034 Bench: start asserted during COLLECT and an 11th in_valid asserted during DONE -> no restart, result unchanged, exactly one done pulse.
REQ-035 Bench: rst after the 5th sample, then a new start and ten scores -> no done from the aborted run, and the second result is correct.
REQ-036 Bench: after done, outputs are held for 20 cycles with no start -> class_idx and max_score remain stable and busy=0.

Source files
------------

// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - streams NUM_CLASSES signed scores and reports the index and value of the largest
module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_score
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] cnt;
  logic             take;
  logic             last;
  logic             better;

  // The first sample always wins so a score equal to MOST_NEG still lands at index 0.
  assign better = (cnt == '0) || ($signed(in_data) > $signed(max_score));
  assign last   = (cnt == LAST_IDX);

  always_comb begin
    state_n = state;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = COLLECT;
      end
      COLLECT: begin
        if (in_valid) begin
          take = 1'b1;
          if (last) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      class_idx <= '0;
      max_score <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == COLLECT);
      done  <= (state_n == DONE);
      if (state == IDLE && start) begin
        cnt       <= '0;
        class_idx <= '0;
        max_score <= MOST_NEG;
      end
      if (take) begin
        // Hold the counter on the final sample so it never wraps inside COLLECT.
        if (!last) cnt <= cnt + 1'b1;
        if (better) begin
          class_idx <= cnt;
          max_score <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - randomized bench for output_argmax against a queue-based argmax model
module tb_output_argmax;

  localparam int N      = 10;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;
  localparam logic signed [DATA_W-1:0] MOST_NEG = -16'sd32768;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] max_score;

  output_argmax #(.NUM_CLASSES(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .class_idx(class_idx), .max_score(max_score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // Reference model: a run is the list of scores accepted since start; result is the first maximum.
  logic signed [DATA_W-1:0] q[$];
  logic                     m_live = 1'b0;
  logic                     m_armed, m_done;
  int                       m_idx;
  logic signed [DATA_W-1:0] m_max;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_armed = 1'b0; m_done = 1'b0; m_idx = 0; m_max = '0; q.delete();
    end else if (m_live) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_armed) begin
        if (start) begin
          m_armed = 1'b1; q.delete(); m_idx = 0; m_max = MOST_NEG;
        end
      end else if (in_valid) begin
        q.push_back($signed(in_data));
        m_idx = 0; m_max = q[0];
        for (int i = 1; i < q.size(); i++)
          if (q[i] > m_max) begin m_max = q[i]; m_idx = i; end
        if (q.size() == N) begin m_armed = 1'b0; m_done = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_cmp++;
      if (busy !== m_armed || done !== m_done || class_idx !== IDX_W'(m_idx) || max_score !== m_max) begin
        n_bad++;
        $display("FAIL model t=%0t busy=%b/%b done=%b/%b idx=%0d/%0d max=%0d/%0d", $time,
                 busy, m_armed, done, m_done, class_idx, m_idx, $signed(max_score), m_max);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int score, input int gap);
    in_valid = 1'b1;
    in_data  = DATA_W'(score);
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    repeat (gap) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int t1[N] = '{3, -5, 7, 2, 7, 0, 1, -1, 6, 4};
  int t4[N] = '{5, 1, 9, -3, 9, 2, 0, 8, -7, 4};
  int sc[N];
  int exp_i, exp_m;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_idx", int'(class_idx), 0);
    check("reset_max", int'($signed(max_score)), 0);
    rst = 1'b0;
    tick();

    // Known sequence, back-to-back; tie at 7 resolves to index 2.
    done_cnt = 0;
    do_start();
    for (int i = 0; i < N; i++) send(t1[i], 0);
    check("t1_done_latency", int'(done), 1);
    tick();
    check("t1_done_width", int'(done), 0);
    check("t1_idx", int'(class_idx), 2);
    check("t1_max", int'($signed(max_score)), 7);
    check("t1_pulses", done_cnt, 1);

    // All scores at the most negative value with random gaps.
    done_cnt = 0;
    do_start();
    for (int i = 0; i < N; i++) send(-32768, int'($urandom_range(5)));
    repeat (3) tick();
    check("t2_idx", int'(class_idx), 0);
    check("t2_max", int'($signed(max_score)), -32768);
    check("t2_pulses", done_cnt, 1);

    // Idle in_valid pulses are ignored; maximum at the last index.
    for (int i = 0; i < 3; i++) send(int'($urandom_range(500)) + 200, 1);
    do_start();
    for (int i = 0; i < N; i++) send((i == N-1) ? 100 : int'($urandom_range(1099)) - 1000, int'($urandom_range(2)));
    repeat (2) tick();
    check("t3_idx", int'(class_idx), 9);
    check("t3_max", int'($signed(max_score)), 100);

    // start during COLLECT, then an extra in_valid plus start during DONE.
    done_cnt = 0;
    do_start();
    for (int i = 0; i < 4; i++) send(t4[i], 0);
    do_start();
    for (int i = 4; i < N; i++) send(t4[i], 0);
    in_valid = 1'b1; in_data = 16'sd30000; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    repeat (3) tick();
    check("t4_idx", int'(class_idx), 2);
    check("t4_max", int'($signed(max_score)), 9);
    check("t4_busy", int'(busy), 0);
    check("t4_pulses", done_cnt, 1);

    // Reset mid-run aborts without done; the next run is clean.
    done_cnt = 0;
    do_start();
    for (int i = 0; i < 5; i++) send(int'($urandom_range(200)), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_abort_busy", int'(busy), 0);
    repeat (3) tick();
    check("t5_abort_pulses", done_cnt, 0);
    do_start();
    for (int i = 0; i < N; i++) send(int'($urandom_range(2000)) - 1000, int'($urandom_range(1)));
    tick();
    check("t5_pulses", done_cnt, 1);

    // Result holds for 20 idle cycles.
    do_start();
    for (int i = 0; i < N; i++) begin
      sc[i] = int'($signed(DATA_W'($urandom)));
      send(sc[i], 0);
    end
    exp_i = 0; exp_m = sc[0];
    for (int i = 1; i < N; i++) if (sc[i] > exp_m) begin exp_m = sc[i]; exp_i = i; end
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t6_hold_idx", int'(class_idx), exp_i);
      check("t6_hold_max", int'($signed(max_score)), exp_m);
      check("t6_hold_busy", int'(busy), 0);
    end

    // Random soak with start and in_valid noise; the per-cycle model compare covers it.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(1)) send(int'($urandom), 0);
      do_start();
      for (int i = 0; i < N; i++) begin
        start = 1'(($urandom_range(3)) == 0);
        send(int'($signed(DATA_W'($urandom_range(7)))) - 4 + ((r % 2) ? int'($signed(DATA_W'($urandom))) : 0),
             int'($urandom_range(3)));
        start = 1'b0;
      end
      repeat (2) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
